// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS iterative multiply/divide unit.
package mips_muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mips_muldiv_cond_negate.sv
// Conditional two's-complement: y = neg ? -x : x.
module mips_cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one bit per cycle.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          state_reg;
    logic [CW-1:0]      count_reg;
    logic [1:0]         op_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic               b_zero_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic [2*WIDTH-1:0] work_reg;
    logic [2*WIDTH-1:0] work_next;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               done_reg;
    logic               dbz_reg;

    logic               start_signed;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_neg;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;

    assign start_signed = md_is_signed(op);
    assign neg_a        = start_signed & a[WIDTH-1];
    assign neg_b        = start_signed & b[WIDTH-1];
    assign res_neg      = sign_a_reg ^ sign_b_reg;

    mips_cond_negate #(.WIDTH(WIDTH)) u_neg_a (
        .x   (a),
        .neg (neg_a),
        .y   (mag_a)
    );

    mips_cond_negate #(.WIDTH(WIDTH)) u_neg_b (
        .x   (b),
        .neg (neg_b),
        .y   (mag_b)
    );

    mips_cond_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .x   (work_reg[WIDTH-1:0]),
        .neg (res_neg),
        .y   (quo_fix)
    );

    // Remainder follows the dividend's sign; with a zero divisor the
    // remainder half ends up holding |a|, so this also restores the original a.
    mips_cond_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .x   (work_reg[2*WIDTH-1:WIDTH]),
        .neg (sign_a_reg),
        .y   (rem_fix)
    );

    mips_cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .x   (work_reg),
        .neg (res_neg),
        .y   (prod_fix)
    );

    // work_reg is {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]}
                  + (work_reg[0] ? {1'b0, operand_reg} : {(WIDTH+1){1'b0}});
        div_trial = work_reg[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, operand_reg};
        work_next = {mul_sum, work_reg[WIDTH-1:1]};
        if (md_is_div(op_reg)) begin
            if (div_diff[WIDTH]) begin
                work_next = {div_trial[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0};
            end else begin
                work_next = {div_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (md_is_div(op_reg)) begin
            res_hi = rem_fix;
            res_lo = b_zero_reg ? {WIDTH{1'b1}} : quo_fix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            op_reg      <= MD_MULT;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            b_zero_reg  <= 1'b0;
            operand_reg <= '0;
            work_reg    <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (hi_we) begin
                        hi_reg <= wdata;
                    end
                    if (lo_we) begin
                        lo_reg <= wdata;
                    end
                    if (start) begin
                        state_reg   <= S_CALC;
                        count_reg   <= '0;
                        op_reg      <= op;
                        sign_a_reg  <= neg_a;
                        sign_b_reg  <= neg_b;
                        b_zero_reg  <= (b == '0);
                        operand_reg <= mag_b;
                        work_reg    <= {{WIDTH{1'b0}}, mag_a};
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state_reg <= S_IDLE;
                    end else begin
                        work_reg  <= work_next;
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == LAST) begin
                            state_reg <= S_FIXUP;
                        end
                    end
                end
                S_FIXUP: begin
                    state_reg <= S_IDLE;
                    if (!cancel) begin
                        hi_reg   <= res_hi;
                        lo_reg   <= res_lo;
                        done_reg <= 1'b1;
                        dbz_reg  <= md_is_div(op_reg) & b_zero_reg;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign dbz  = dbz_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
